fetch_unit: RTL and testbench

- Instruction fetch sequencer; consumes the PC register value and performs one memory read per fetch request.
- Latches the returned word into IR and reports completion to the control FSM.
- Drives the memory-side handshake: the address and enable are held stable until memory asserts ready.
- Sits between the PC register and the unified memory port; the control FSM pulses start in the fetch state and waits for ir_valid before asserting LD_PC with the INC source.

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: one memory read per start pulse, result latched into IR.
// Optional FETCH_ALIGN_TRAP_EN: a misaligned PC raises fault instead of fetching.
module fetch_unit #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] PC,
    input  logic        mem_r,
    input  logic [15:0] mem_data,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic [15:0] IR,
    output logic        ir_valid,
    output logic        busy,
    output logic        timeout,
    output logic        fault
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [15:0]      addr_q, addr_d;
    logic             en_q, en_d;
    logic [15:0]      ir_q, ir_d;
    logic             irv_q, irv_d;
    logic             busy_q, busy_d;
    logic             tmo_q, tmo_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic misaligned;
    logic tmo_hit;

`ifdef FETCH_ALIGN_TRAP_EN
    assign misaligned = PC[0];
`else
    assign misaligned = 1'b0;
`endif

    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        en_d    = en_q;
        ir_d    = ir_q;
        irv_d   = irv_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        fault_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    irv_d = 1'b0;
                    if (misaligned) begin
                        fault_d = 1'b1;
                    end else begin
                        // Bit 0 is dropped: word-aligned access regardless of PC[0].
                        addr_d  = PC & 16'hFFFE;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Ready wins over an expiring timeout on the same edge.
                if (mem_r) begin
                    ir_d    = mem_data;
                    irv_d   = 1'b1;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            en_q    <= 1'b0;
            ir_q    <= '0;
            irv_q   <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            ir_q    <= ir_d;
            irv_q   <= irv_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_en   = en_q;
    assign IR       = ir_q;
    assign ir_valid = irv_q;
    assign busy     = busy_q;
    assign timeout  = tmo_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected completions,
// a negedge monitor pops them whenever ir_valid rises or timeout/fault pulses.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, start, mem_r;
    logic [15:0] PC, mem_data;
    logic [15:0] mem_addr, IR;
    logic        mem_en, ir_valid, busy, timeout, fault;

    fetch_unit #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .PC(PC),
        .mem_r(mem_r), .mem_data(mem_data),
        .mem_addr(mem_addr), .mem_en(mem_en), .IR(IR),
        .ir_valid(ir_valid), .busy(busy), .timeout(timeout), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_DONE = 0, EV_TMO = 1, EV_FAULT = 2} ev_e;
    typedef struct {
        ev_e         kind;
        logic [15:0] ir;
        logic [15:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input ev_e k, input logic [15:0] ir, input logic [15:0] addr);
        exp_t e;
        e.kind = k;
        e.ir   = ir;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    // Monitor
    logic irv_prev = 1'b0;
    ev_e  mon_kind;
    exp_t mon_e;

    always @(negedge clk) begin
        if (reset) begin
            irv_prev = 1'b0;
        end else begin
            if ((ir_valid && !irv_prev) || timeout || fault) begin
                mon_kind = (ir_valid && !irv_prev) ? EV_DONE : (timeout ? EV_TMO : EV_FAULT);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 64'(mon_kind), 64'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ev_kind", 64'(mon_kind), 64'(mon_e.kind));
                    check("ev_IR", 64'(IR), 64'(mon_e.ir));
                    check("ev_addr", 64'(mem_addr), 64'(mon_e.addr));
                end
            end
            irv_prev = ir_valid;
        end
    end

    function automatic logic [63:0] all_outs();
        return 64'({mem_addr, IR, mem_en, ir_valid, busy, timeout, fault});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int en_cnt;
        logic en_seen;
        reset = 1'b1; start = 1'b0; mem_r = 1'b0; PC = '0; mem_data = '0;
        en_seen = 1'b0;
        tick(); tick();
        check("reset_outs", all_outs(), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            mem_r    = 1'($urandom_range(0, 1));
            mem_data = 16'($urandom);
            tick();
            check("idle_outs", all_outs(), 64'd0);
        end
        mem_r = 1'b0;

        // Single-cycle fetch
        PC = 16'h3000; start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_addr", 64'(mem_addr), 64'h3000);
        check("t2_en_busy", 64'({mem_en, busy, ir_valid}), 64'(3'b110));
        expect_ev(EV_DONE, 16'h1234, 16'h3000);
        mem_r = 1'b1; mem_data = 16'h1234;
        tick();
        mem_r = 1'b0;
        check("t2_done", 64'({mem_en, busy, ir_valid, IR}), 64'({3'b001, 16'h1234}));

        // Timeout after 15 WAIT edges
        PC = 16'h3004; start = 1'b1;
        tick();
        start = 1'b0;
        expect_ev(EV_TMO, 16'h1234, 16'h3004);
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("tmo_wait", 64'({mem_en, busy, timeout, ir_valid}), 64'(4'b1100));
        end
        tick();
        check("tmo_pulse", 64'({mem_en, busy, timeout, ir_valid, IR}), 64'({4'b0010, 16'h1234}));
        tick();
        check("tmo_clear", 64'(timeout), 64'd0);

        // Ready delayed to the 5th WAIT edge, stray start ignored
        PC = 16'h3002; start = 1'b1;
        tick();
        start = 1'b0;
        en_cnt = mem_en ? 1 : 0;
        for (int i = 1; i <= 4; i++) begin
            start = (i == 2);
            if (i == 2) PC = 16'h4000;
            tick();
            if (mem_en) en_cnt++;
            check("t3_addr_stable", 64'(mem_addr), 64'h3002);
        end
        start = 1'b0;
        expect_ev(EV_DONE, 16'hBEEF, 16'h3002);
        mem_r = 1'b1; mem_data = 16'hBEEF;
        tick();
        if (mem_en) en_cnt++;
        mem_r = 1'b0;
        check("t3_en_cycles", 64'(en_cnt), 64'd5);
        check("t3_done", 64'({ir_valid, busy, IR}), 64'({2'b10, 16'hBEEF}));

        // Reset on the 3rd WAIT cycle, then a normal fetch
        PC = 16'h3006; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rst_mid", 64'({mem_en, busy, ir_valid, timeout, IR}), 64'd0);
        reset = 1'b0;
        PC = 16'h3008; start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_restart_addr", 64'({mem_en, mem_addr}), 64'({1'b1, 16'h3008}));
        expect_ev(EV_DONE, 16'h5A5A, 16'h3008);
        tick();
        mem_r = 1'b1; mem_data = 16'h5A5A;
        tick();
        mem_r = 1'b0;
        check("rst_restart_done", 64'({ir_valid, IR}), 64'({1'b1, 16'h5A5A}));

        // Misaligned PC
`ifdef FETCH_ALIGN_TRAP_EN
        expect_ev(EV_FAULT, 16'h5A5A, 16'h3008);
        PC = 16'h3001; start = 1'b1;
        tick();
        start = 1'b0;
        check("align_fault", 64'({fault, mem_en, busy, ir_valid, IR}), 64'({4'b1000, 16'h5A5A}));
        en_seen = mem_en;
        tick();
        check("align_fault_clear", 64'(fault), 64'd0);
        for (int i = 0; i < 3; i++) begin
            en_seen = en_seen | mem_en;
            tick();
        end
        check("align_no_en", 64'(en_seen | mem_en), 64'd0);
`else
        PC = 16'h3001; start = 1'b1;
        tick();
        start = 1'b0;
        check("align_addr", 64'({mem_en, mem_addr}), 64'({1'b1, 16'h3000}));
        expect_ev(EV_DONE, 16'h7777, 16'h3000);
        mem_r = 1'b1; mem_data = 16'h7777;
        tick();
        mem_r = 1'b0;
        check("align_done", 64'({ir_valid, IR, fault}), 64'({1'b1, 16'h7777, 1'b0}));
        check("align_no_trap", 64'(en_seen | fault), 64'd0);
`endif

        // Top of address space; mem_r coincident with start is ignored
        PC = 16'hFFFE; start = 1'b1; mem_r = 1'b1; mem_data = 16'h1111;
        tick();
        start = 1'b0;
        check("top_addr", 64'({mem_en, mem_addr, ir_valid}), 64'({1'b1, 16'hFFFE, 1'b0}));
        expect_ev(EV_DONE, 16'hCAFE, 16'hFFFE);
        mem_data = 16'hCAFE;
        tick();
        mem_r = 1'b0;
        check("top_done", 64'({ir_valid, IR}), 64'({1'b1, 16'hCAFE}));

        tick(); tick(); tick();
        check("irv_hold", 64'({ir_valid, IR, busy, mem_en}), 64'({1'b1, 16'hCAFE, 2'b00}));

        tick();
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
